layer_stream_arb: RTL and testbench
===================================

LAYER_STREAM_ARB -- requirements
Module: layer_stream_arb

Interface
REQ-001 SHALL have parameter T, default 9: data element width in bits (signed).
REQ-002 SHALL have parameter N, default 2: input elements per vector.
REQ-003 SHALL have parameter M, default 5: output elements per vector.
REQ-004 SHALL have parameter TAGDEPTH, default 4: tag FIFO depth, power of two.
REQ-005 SHALL have port: clk  in  1  single clock; all state on rising edge.
REQ-006 SHALL have port: reset  in  1  asynchronous, active-high reset.
REQ-007 SHALL have ports: s0_valid/s1_valid  in  1; s0_data/s1_data  in  T; s0_ready/s1_ready  out  1. These are the requester input streams.
REQ-008 SHALL have ports: l_valid  out  1; l_data  out  T; l_ready  in  1. These drive the shared layer's s_valid/data_in and take its s_ready.
REQ-009 SHALL have ports: lo_valid  in  1; lo_data  in  T; lo_ready  out  1. These take the layer's m_valid/data_out and drive its m_ready.
REQ-010 SHALL have ports: m0_valid/m1_valid  out  1; m0_data/m1_data  out  T; m0_ready/m1_ready  in  1. These are the requester output streams.

Function
REQ-011 SHALL transfer a beat only on a cycle where valid and ready are both 1; payload SHALL be unchanged.
REQ-012 SHALL run the input FSM states IDLE, FWD0 and FWD1.
REQ-013 IDLE: all s*_ready=0, l_valid=0; if any s*_valid=1 and the tag FIFO is not full, SHALL go to FWDx next cycle, with x chosen by REQ-016, and push tag x.
REQ-014 FWDx: l_valid=sx_valid, l_data=sx_data, sx_ready=l_ready, other s*_ready=0; an element counter SHALL count handshakes; the Nth handshake returns to IDLE and clears the counter.
REQ-015 Vectors SHALL never interleave: all N elements come from one requester; each vector costs one IDLE bubble cycle.
REQ-016 Arbitration SHALL be round-robin at vector granularity: the requester not most recently granted has priority; a lone valid requester SHALL be granted.
REQ-017 The tag FIFO holds 1-bit requester IDs; push is blocked when count==TAGDEPTH (no bypass via same-cycle pop); push and pop in the same cycle SHALL leave count unchanged.
REQ-018 Output routing: if the FIFO is empty, lo_ready=0 and m0_valid=m1_valid=0; else, with head tag h, mh_valid=lo_valid, mh_data=lo_data, lo_ready=mh_ready, and the other m*_valid=0.
REQ-019 An output counter SHALL count lo handshakes; the Mth pops the FIFO and clears the counter.
REQ-020 Outputs SHALL be in strict grant order: a stalled head requester SHALL block the other requester's results (no reordering).
REQ-021 Inactive data outputs (l_data, m*_data) SHALL be driven 0.
REQ-022 Counter widths: element counter clog2(N), output counter clog2(M), FIFO pointers clog2(TAGDEPTH), occupancy count clog2(TAGDEPTH)+1.

Reset
REQ-023 On reset=1, asynchronously: FSM=IDLE, counters=0, FIFO empty, last-granted=1 (so requester 0 wins first).
REQ-024 During and after reset until a grant: s0_ready=s1_ready=l_valid=lo_ready=m0_valid=m1_valid=0.
REQ-025 A reset mid-vector SHALL discard the partial vector and pending tags; the system SHALL reset the layer in the same cycle.

Configuration
REQ-026 Macro LAYER_ARB_STRICT_PRI_EN: when defined, arbitration is strict priority (s0 always wins when valid) and the last-granted register is omitted; when undefined, round-robin per REQ-016 applies.

Verification
REQ-027 Only s0 sends vector {3,-7}; layer returns 5 values -> all 5 appear on m0 in order; m1_valid never 1; FIFO empty after.
REQ-028 s0 and s1 both continuously valid, 6 vectors each -> grant order 0,1,0,1,...; with LAYER_ARB_STRICT_PRI_EN, all s0 vectors granted before any s1.
REQ-029 m0_ready=0, s0 sends 5 vectors -> 4 granted, then s0_ready stays 0; raising m0_ready drains 5 outputs, then the 5th vector is granted.
REQ-030 Head tag=1, m1_ready=0, m0_ready=1 -> lo_ready=0 and m0_valid=0 until m1 drains its 5 outputs.
REQ-031 reset pulsed after 1 of 2 elements of an s1 vector -> next cycle FSM IDLE, all valid/ready outputs 0, FIFO empty; next grant goes to s0.
REQ-032 Random valid/ready at 50% on all ports, 5000 vectors per requester through layer_5_2_5_9 -> every m0/m1 output matches the per-requester golden file, 0 errors.

Source files
------------

// File: rtl/layer_stream_arb.sv
// rtl/layer_stream_arb.sv - two-requester vector arbiter around a shared N-in/M-out layer (option: LAYER_ARB_STRICT_PRI_EN)
module layer_stream_arb #(
  parameter int T        = 9,
  parameter int N        = 2,
  parameter int M        = 5,
  parameter int TAGDEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         s0_valid,
  input  logic [T-1:0] s0_data,
  output logic         s0_ready,
  input  logic         s1_valid,
  input  logic [T-1:0] s1_data,
  output logic         s1_ready,
  output logic         l_valid,
  output logic [T-1:0] l_data,
  input  logic         l_ready,
  input  logic         lo_valid,
  input  logic [T-1:0] lo_data,
  output logic         lo_ready,
  output logic         m0_valid,
  output logic [T-1:0] m0_data,
  input  logic         m0_ready,
  output logic         m1_valid,
  output logic [T-1:0] m1_data,
  input  logic         m1_ready
);

  localparam int EW = (N > 1) ? $clog2(N) : 1;
  localparam int OW = (M > 1) ? $clog2(M) : 1;
  localparam int PW = (TAGDEPTH > 1) ? $clog2(TAGDEPTH) : 1;
  localparam int CW = $clog2(TAGDEPTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD0 = 2'd1,
    FWD1 = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nx;
  logic [EW-1:0]       elem_cnt;
  logic [OW-1:0]       out_cnt;
  logic [TAGDEPTH-1:0] tag_mem;
  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       rd_ptr;
  logic [CW-1:0]       count;

  logic any_valid;
  logic grant_id;
  logic fifo_full;
  logic fifo_empty;
  logic push;
  logic pop;
  logic head;
  logic l_hs;
  logic lo_hs;
  logic elem_last;
  logic out_last;

  assign any_valid  = s0_valid | s1_valid;
  assign fifo_full  = (count == CW'(TAGDEPTH));
  assign fifo_empty = (count == '0);
  assign push       = (state == IDLE) && any_valid && !fifo_full;
  assign head       = tag_mem[rd_ptr];
  assign elem_last  = (elem_cnt == EW'(N - 1));
  assign out_last   = (out_cnt == OW'(M - 1));
  assign lo_hs      = lo_valid & lo_ready;
  assign pop        = lo_hs & out_last;

`ifdef LAYER_ARB_STRICT_PRI_EN
  // s0 always wins; no history is kept
  assign grant_id = ~s0_valid;
`else
  logic last_grant;

  assign grant_id = (s0_valid && s1_valid) ? ~last_grant : s1_valid;

  // remember the requester of the latest grant; reset value lets s0 win first
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     last_grant <= 1'b1;
    else if (push) last_grant <= grant_id;
  end
`endif

  // input FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // input FSM: IDLE bubble grants one requester, FWDx passes exactly N beats
  always_comb begin
    state_nx = state;
    s0_ready = 1'b0;
    s1_ready = 1'b0;
    l_valid  = 1'b0;
    l_data   = '0;
    l_hs     = 1'b0;
    case (state)
      IDLE: begin
        if (push) state_nx = grant_id ? FWD1 : FWD0;
      end
      FWD0: begin
        l_valid  = s0_valid;
        l_data   = s0_valid ? s0_data : '0;
        s0_ready = l_ready;
        l_hs     = s0_valid & l_ready;
        if (l_hs && elem_last) state_nx = IDLE;
      end
      FWD1: begin
        l_valid  = s1_valid;
        l_data   = s1_valid ? s1_data : '0;
        s1_ready = l_ready;
        l_hs     = s1_valid & l_ready;
        if (l_hs && elem_last) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // count beats of the vector being forwarded into the layer
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     elem_cnt <= '0;
    else if (l_hs) elem_cnt <= elem_last ? '0 : elem_cnt + 1'b1;
  end

  // count results leaving the layer for the head-of-queue requester
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      out_cnt <= '0;
    else if (lo_hs) out_cnt <= out_last ? '0 : out_cnt + 1'b1;
  end

  // tag storage needs no reset: occupancy decides what is valid
  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr] <= grant_id;
  end

  // tag FIFO pointers and occupancy; push and pop together keep the count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PW'(TAGDEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == PW'(TAGDEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // route layer results to the requester named by the head tag, in grant order
  always_comb begin
    lo_ready = 1'b0;
    m0_valid = 1'b0;
    m1_valid = 1'b0;
    m0_data  = '0;
    m1_data  = '0;
    if (!fifo_empty) begin
      if (head) begin
        m1_valid = lo_valid;
        m1_data  = lo_valid ? lo_data : '0;
        lo_ready = m1_ready;
      end else begin
        m0_valid = lo_valid;
        m0_data  = lo_valid ? lo_data : '0;
        lo_ready = m0_ready;
      end
    end
  end

endmodule

// File: tb/tb_layer_stream_arb.sv
// tb/tb_layer_stream_arb.sv - scoreboard bench for layer_stream_arb with a behavioural layer model
module tb_layer_stream_arb;
  localparam int T        = 9;
  localparam int N        = 2;
  localparam int M        = 5;
  localparam int TAGDEPTH = 4;
  localparam int NRAND    = 300;

  typedef logic [T-1:0]        elem_t;
  typedef logic signed [T-1:0] selem_t;

  logic  clk = 1'b0;
  logic  reset;
  logic  s0_valid, s1_valid, s0_ready, s1_ready;
  elem_t s0_data, s1_data;
  logic  l_valid, l_ready;
  elem_t l_data;
  logic  lo_valid, lo_ready;
  elem_t lo_data;
  logic  m0_valid, m1_valid, m0_ready, m1_ready;
  elem_t m0_data, m1_data;

  layer_stream_arb #(.T(T), .N(N), .M(M), .TAGDEPTH(TAGDEPTH)) dut (
    .clk(clk), .reset(reset),
    .s0_valid(s0_valid), .s0_data(s0_data), .s0_ready(s0_ready),
    .s1_valid(s1_valid), .s1_data(s1_data), .s1_ready(s1_ready),
    .l_valid(l_valid), .l_data(l_data), .l_ready(l_ready),
    .lo_valid(lo_valid), .lo_data(lo_data), .lo_ready(lo_ready),
    .m0_valid(m0_valid), .m0_data(m0_data), .m0_ready(m0_ready),
    .m1_valid(m1_valid), .m1_data(m1_data), .m1_ready(m1_ready)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    failures = 0;
  elem_t src_q[2][$];
  elem_t exp_q[2][$];
  elem_t lay_q[$];
  elem_t lbuf[$];
  int    grant_log[$];
  int    grant_m0cnt[$];
  int    elem_idx = 0;
  int    cur_src = 0;
  int    m_count[2] = '{0, 0};
  int    m1_valid_cycles = 0;
  int    src_pct[2] = '{0, 0};
  int    mrdy_pct[2] = '{0, 0};
  int    lrdy_pct = 0;
  int    lov_pct = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // the shared layer: result k is a weighted sum of the vector's elements
  function automatic elem_t layer_out(input selem_t v[N], input int k);
    int acc;
    acc = k;
    for (int j = 0; j < N; j++) acc += int'(v[j]) * (j + k + 1);
    return elem_t'(acc);
  endfunction

  task automatic add_vector(input int r, input selem_t v[N]);
    for (int j = 0; j < N; j++) src_q[r].push_back(elem_t'(v[j]));
    for (int k = 0; k < M; k++) exp_q[r].push_back(layer_out(v, k));
  endtask

  task automatic add_random(input int r);
    selem_t v[N];
    for (int j = 0; j < N; j++) v[j] = selem_t'($urandom);
    add_vector(r, v);
  endtask

  function automatic logic hit(input int pct);
    return int'($urandom_range(99)) < pct;
  endfunction

  task automatic clear_model();
    src_q[0].delete(); src_q[1].delete();
    exp_q[0].delete(); exp_q[1].delete();
    lay_q.delete(); lbuf.delete();
    grant_log.delete(); grant_m0cnt.delete();
    elem_idx = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    reset = 1'b1;
    clear_model();
    @(posedge clk); #2;
    reset = 1'b0;
  endtask

  task automatic check_quiet(input string name);
    check(name, int'({s0_ready, s1_ready, l_valid, lo_ready, m0_valid, m1_valid}), 0);
  endtask

  task automatic wait_drain(input int budget, input string name);
    int n;
    n = 0;
    while (n < budget && !(src_q[0].size() == 0 && src_q[1].size() == 0 &&
                           exp_q[0].size() == 0 && exp_q[1].size() == 0 && lay_q.size() == 0)) begin
      @(negedge clk);
      n++;
    end
    check({name, "_drained"}, int'(n < budget), 1);
    repeat (3) @(negedge clk);
  endtask

  // sources, layer model and sinks: sample handshakes at negedge, drive after posedge
  initial begin : env
    logic   hs0, hs1, hsl, hslo;
    elem_t  ld, dump;
    selem_t v[N];
    s0_valid = 1'b0; s0_data = '0; s1_valid = 1'b0; s1_data = '0;
    l_ready = 1'b0; lo_valid = 1'b0; lo_data = '0; m0_ready = 1'b0; m1_ready = 1'b0;
    forever begin
      @(negedge clk);
      hs0  = s0_valid && s0_ready;
      hs1  = s1_valid && s1_ready;
      hsl  = l_valid && l_ready;
      ld   = l_data;
      hslo = lo_valid && lo_ready;
      @(posedge clk); #1;
      if (hs0 && src_q[0].size() > 0) dump = src_q[0].pop_front();
      if (hs1 && src_q[1].size() > 0) dump = src_q[1].pop_front();
      if (hsl) begin
        lbuf.push_back(ld);
        if (lbuf.size() == N) begin
          for (int j = 0; j < N; j++) v[j] = selem_t'(lbuf[j]);
          for (int k = 0; k < M; k++) lay_q.push_back(layer_out(v, k));
          lbuf.delete();
        end
      end
      if (hslo && lay_q.size() > 0) dump = lay_q.pop_front();
      s0_valid = (src_q[0].size() > 0) && hit(src_pct[0]);
      s0_data  = s0_valid ? src_q[0][0] : elem_t'($urandom);
      s1_valid = (src_q[1].size() > 0) && hit(src_pct[1]);
      s1_data  = s1_valid ? src_q[1][0] : elem_t'($urandom);
      l_ready  = hit(lrdy_pct);
      lo_valid = (lay_q.size() > 0) && hit(lov_pct);
      lo_data  = lo_valid ? lay_q[0] : elem_t'($urandom);
      m0_ready = hit(mrdy_pct[0]);
      m1_ready = hit(mrdy_pct[1]);
    end
  end

  // monitor: scoreboard compare of requester outputs plus grant bookkeeping
  initial begin : monitor
    logic  mv[2], mr[2], sv[2], sr[2];
    elem_t md[2], sd[2];
    int    src;
    forever begin
      @(negedge clk);
      mv[0] = m0_valid; mr[0] = m0_ready; md[0] = m0_data;
      mv[1] = m1_valid; mr[1] = m1_ready; md[1] = m1_data;
      sv[0] = s0_valid; sr[0] = s0_ready; sd[0] = s0_data;
      sv[1] = s1_valid; sr[1] = s1_ready; sd[1] = s1_data;
      if (m1_valid) m1_valid_cycles++;
      for (int r = 0; r < 2; r++) begin
        if (mv[r] && mr[r]) begin
          if (exp_q[r].size() == 0) check($sformatf("m%0d_unexpected", r), 1, 0);
          else check($sformatf("m%0d_data", r), int'(md[r]), int'(exp_q[r].pop_front()));
          m_count[r]++;
        end else if (!mv[r]) begin
          check($sformatf("m%0d_idle_data", r), int'(md[r]), 0);
        end
      end
      if (!l_valid) check("l_idle_data", int'(l_data), 0);
      if ((sv[0] && sr[0]) || (sv[1] && sr[1])) begin
        src = (sv[1] && sr[1]) ? 1 : 0;
        check("single_grant", int'(sv[0] && sr[0] && sv[1] && sr[1]), 0);
        check("l_handshake", int'(l_valid && l_ready), 1);
        check("l_payload", int'(l_data), int'(sd[src]));
        if (elem_idx == 0) begin
          grant_log.push_back(src);
          grant_m0cnt.push_back(m_count[0]);
          cur_src = src;
        end else begin
          check("no_interleave", src, cur_src);
        end
        elem_idx = (elem_idx + 1) % N;
      end
    end
  end

  initial begin : watchdog
    #700000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int     g0, n, viol, base0, base1, expg;
    selem_t v[N];
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_quiet("reset_state");
    check("reset_data", int'(l_data | m0_data | m1_data), 0);
    @(posedge clk); #2;
    reset = 1'b0;
    @(negedge clk);
    check_quiet("post_reset_idle");

    // single requester, fixed vector {3,-7}
    src_pct = '{100, 100}; mrdy_pct = '{100, 100}; lrdy_pct = 100; lov_pct = 100;
    base0 = m_count[0]; m1_valid_cycles = 0;
    v[0] = selem_t'(3); v[1] = selem_t'(-7);
    add_vector(0, v);
    wait_drain(200, "single");
    check("single_m0_count", m_count[0] - base0, M);
    check("single_m1_valid", m1_valid_cycles, 0);
    check("single_fifo_empty", int'(lo_ready), 0);

    // both requesters continuously valid
    do_reset();
    for (int i = 0; i < 6; i++) begin add_random(0); add_random(1); end
    wait_drain(1000, "arb");
    check("arb_grants", grant_log.size(), 12);
    for (int i = 0; i < grant_log.size() && i < 12; i++) begin
`ifdef LAYER_ARB_STRICT_PRI_EN
      expg = (i < 6) ? 0 : 1;
`else
      expg = i % 2;
`endif
      check($sformatf("arb_grant%0d", i), grant_log[i], expg);
    end

    // stalled sink fills the tag FIFO
    mrdy_pct[0] = 0; g0 = grant_log.size(); base0 = m_count[0];
    repeat (5) add_random(0);
    repeat (40) @(negedge clk);
    viol = 0;
    repeat (40) begin @(negedge clk); if (s0_ready) viol++; end
    check("full_grants", grant_log.size() - g0, TAGDEPTH);
    check("full_s0_ready_low", viol, 0);
    mrdy_pct[0] = 100;
    n = 0;
    while (n < 200 && grant_log.size() - g0 < 5) begin @(negedge clk); n++; end
    check("full_fifth_grant", int'(grant_log.size() - g0 >= 5), 1);
    if (grant_log.size() - g0 >= 5)
      check("full_drain_first", int'(grant_m0cnt[g0 + 4] - base0 >= M), 1);
    wait_drain(500, "full");

    // head tag 1 stalled blocks requester 0 results
    do_reset();
    mrdy_pct = '{100, 0}; g0 = grant_log.size(); base0 = m_count[0]; base1 = m_count[1];
    add_random(1);
    n = 0;
    while (n < 50 && grant_log.size() - g0 < 1) begin @(negedge clk); n++; end
    add_random(0);
    viol = 0;
    repeat (40) begin @(negedge clk); if (lo_ready || m0_valid) viol++; end
    check("hol_blocked", viol, 0);
    check("hol_m0_none", m_count[0] - base0, 0);
    mrdy_pct[1] = 100;
    wait_drain(300, "hol");
    check("hol_m1_count", m_count[1] - base1, M);
    check("hol_m0_count", m_count[0] - base0, M);

    // reset after the first element of an s1 vector
    do_reset();
    add_random(1);
    n = 0;
    while (n < 50 && !(s1_valid && s1_ready)) begin @(negedge clk); n++; end
    check("midreset_started", int'(s1_valid && s1_ready), 1);
    @(posedge clk); #2;
    reset = 1'b1;
    clear_model();
    @(negedge clk);
    check_quiet("midreset_during");
    @(posedge clk); #2;
    reset = 1'b0;
    @(negedge clk);
    check_quiet("midreset_after");
    add_random(0); add_random(1);
    wait_drain(200, "midreset");
    check("midreset_first_grant", (grant_log.size() > 0) ? grant_log[0] : -1, 0);

    // randomized traffic at 50% on every port
    src_pct = '{50, 50}; mrdy_pct = '{50, 50}; lrdy_pct = 50; lov_pct = 50;
    base0 = m_count[0]; base1 = m_count[1];
    for (int i = 0; i < NRAND; i++) begin add_random(0); add_random(1); end
    wait_drain(40000, "random");
    check("random_m0_count", m_count[0] - base0, NRAND * M);
    check("random_m1_count", m_count[1] - base1, NRAND * M);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
